// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Replays one host ALU command (opcode, A, B) onto the ALU front panel's
//   8-bit switch bus as three enter-qualified transfers. It then waits a
//   fixed settle time, captures the 16-bit ALU result and returns it on a
//   valid/ready response port.
//
// Ports
//   clk                      single clock, rising edge
//   rst                      asynchronous reset, active low
//   cmd_valid/cmd_ready      command handshake
//   cmd_opcode/cmd_a/cmd_b   command fields
//   switch, enter            ALU front-panel drive (registered)
//   result_in                ALU result
//   rsp_valid/rsp_ready      response handshake
//   rsp_result, rsp_err      captured result, opcode 13..15 flag
//   abort                    cancels the sequence in flight
//   busy                     high in every state except IDLE
//   done_cnt                 responses delivered, wraps

module alu_cmd_sequencer #(
   parameter int SETUP_CYC = 2,
   parameter int WAIT_CYC  = 10,
   parameter int CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [3:0]       cmd_opcode,
   input  logic [7:0]       cmd_a,
   input  logic [7:0]       cmd_b,
   output logic [7:0]       switch,
   output logic             enter,
   input  logic [15:0]      result_in,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [15:0]      rsp_result,
   output logic             rsp_err,
   input  logic             abort,
   output logic             busy,
   output logic [CNT_W-1:0] done_cnt
);

   typedef enum logic [3:0] {
      ST_IDLE, ST_OPC, ST_OPC_EN, ST_A, ST_A_EN, ST_B, ST_B_EN, ST_WAIT, ST_DONE
   } state_t;

   localparam logic [15:0] SETUP_LAST = 16'(SETUP_CYC - 1);
   localparam logic [15:0] WAIT_LAST  = 16'(WAIT_CYC - 1);

   state_t      state, state_nxt;
   logic [15:0] tmr, tmr_nxt;

   // Latched command fields
   logic [3:0]  opc_q;
   logic [7:0]  a_q, b_q;
   logic        err_q;

   logic        accept, capture, deliver;
   logic [3:0]  opc_d;
   logic [7:0]  a_d, b_d;
   logic [7:0]  switch_nxt;
   logic        enter_nxt, busy_nxt, ready_nxt, rsp_valid_nxt;

   // State register and in-state cycle timer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= ST_IDLE;
         tmr   <= '0;
      end else begin
         state <= state_nxt;
         tmr   <= tmr_nxt;
      end
   end

   // Next-state logic; abort overrides everything outside IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (cmd_valid)           state_nxt = ST_OPC;
         ST_OPC:    if (tmr == SETUP_LAST)   state_nxt = ST_OPC_EN;
         ST_OPC_EN:                          state_nxt = ST_A;
         ST_A:      if (tmr == SETUP_LAST)   state_nxt = ST_A_EN;
         ST_A_EN:                            state_nxt = ST_B;
         ST_B:      if (tmr == SETUP_LAST)   state_nxt = ST_B_EN;
         ST_B_EN:                            state_nxt = ST_WAIT;
         ST_WAIT:   if (tmr == WAIT_LAST)    state_nxt = ST_DONE;
         ST_DONE:   if (rsp_ready)           state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
      if (abort && (state != ST_IDLE)) state_nxt = ST_IDLE;
   end

   // Output logic: every output is registered, so the values are derived
   // from the state being entered rather than the current one.
   always_comb begin
      accept  = (state == ST_IDLE) && cmd_valid;
      capture = (state == ST_WAIT) && (state_nxt == ST_DONE);
      deliver = (state == ST_DONE) && (state_nxt == ST_IDLE) && !abort;

      // On the accept edge the field registers are still being loaded,
      // so the first switch value must come straight from the command.
      opc_d = accept ? cmd_opcode : opc_q;
      a_d   = a_q;
      b_d   = b_q;

      switch_nxt = 8'h00;
      case (state_nxt)
         ST_OPC, ST_OPC_EN: switch_nxt = {4'h0, opc_d};
         ST_A,   ST_A_EN:   switch_nxt = a_d;
         ST_B,   ST_B_EN:   switch_nxt = b_d;
         default:           switch_nxt = 8'h00;
      endcase

      enter_nxt     = (state_nxt == ST_OPC_EN) || (state_nxt == ST_A_EN) ||
                      (state_nxt == ST_B_EN);
      busy_nxt      = (state_nxt != ST_IDLE);
      ready_nxt     = (state_nxt == ST_IDLE);
      rsp_valid_nxt = (state_nxt == ST_DONE);

      tmr_nxt = (state_nxt != state) ? 16'h0000 : tmr + 16'h0001;
   end

   // Command field capture (data only, no reset needed)
   always_ff @(posedge clk) begin
      if (accept) begin
         opc_q <= cmd_opcode;
         a_q   <= cmd_a;
         b_q   <= cmd_b;
         err_q <= (cmd_opcode >= 4'd13);
      end
   end

   // Registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         switch     <= 8'h00;
         enter      <= 1'b0;
         busy       <= 1'b0;
         cmd_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= 16'h0000;
         rsp_err    <= 1'b0;
         done_cnt   <= '0;
      end else begin
         switch    <= switch_nxt;
         enter     <= enter_nxt;
         busy      <= busy_nxt;
         cmd_ready <= ready_nxt;
         rsp_valid <= rsp_valid_nxt;
         if (capture) begin
            rsp_result <= result_in;
            rsp_err    <= err_q;
         end
         if (deliver) done_cnt <= done_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Host-side initiator for the team's switch/enter ALU front panel.
- Accepts one complete ALU command (opcode, operand A, operand B) through a valid/ready handshake.
- Replays it on the ALU's 8-bit switch bus as three enter-qualified transfers: opcode, then A, then B.
- Waits a fixed settle time covering the sequential multiplier, then captures the ALU's 16-bit result and returns it through a valid/ready response port.
- Replaces manual switch/enter operation in automated system tests.

Parameters:
- SETUP_CYC, 2, cycles each field is driven on switch before its enter pulse (legal range ≥1).
- WAIT_CYC, 10, cycles from the third enter pulse to result capture; covers the 8-bit sequential multiply (legal range ≥1).
- CNT_W, 8, width of the completed-command counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_opcode  in  4  ALU opcode.
- cmd_a  in  8  operand A.
- cmd_b  in  8  operand B.
- switch  out  8  drives the ALU switch input.
- enter  out  1  single-cycle strobe to the ALU.
- result_in  in  16  ALU result output.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed.
- rsp_result  out  16  captured result.
- rsp_err  out  1  opcode was 13, 14 or 15 (debug/undefined/reset codes).
- abort  in  1  cancel the sequence in flight.
- busy  out  1  high in every state except IDLE.
- done_cnt  out  CNT_W  count of responses delivered.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, switch=0, enter=0, rsp_valid=0, rsp_result=0, rsp_err=0, done_cnt=0, busy=0, cmd_ready=1 after release. All outputs are registered.
- States: IDLE, OPC, OPC_EN, A, A_EN, B, B_EN, WAIT, DONE.
- IDLE:
  - cmd_ready=1, switch=0.
  - On edge k with cmd_valid=1, latch opcode, a and b, and compute err = (opcode ≥ 13).
  - Go to OPC. cmd_ready=0 from cycle k+1.
- OPC / A / B:
  - switch = {4'b0, opcode}, a, or b respectively, for exactly SETUP_CYC cycles.
  - Then go to the matching _EN state.
- _EN states:
  - enter=1 for exactly one cycle; switch keeps the same field.
  - OPC_EN→A, A_EN→B, B_EN→WAIT.
- Timing with accept at edge k, S=SETUP_CYC:
  - enter high in cycles k+S+1, k+2S+2 and k+3S+3.
  - enter is never high in two consecutive cycles.
- WAIT:
  - switch=0 for WAIT_CYC cycles.
  - On the edge ending the last WAIT cycle, rsp_result←result_in and rsp_err←err; go to DONE.
  - rsp_valid is first high in cycle k+3S+3+WAIT_CYC+1.
- DONE:
  - rsp_valid=1; rsp_result and rsp_err stay stable until rsp_ready=1 is sampled.
  - On that edge: rsp_valid→0, done_cnt+1 (wraps modulo 2^CNT_W), go to IDLE.
  - A new command can be accepted on the edge following the return to IDLE; no back-to-back accept in the same edge as the handshake.
- Erroneous opcodes (≥13) are still fully sequenced; only rsp_err marks them.
- abort:
  - Sampled in any state other than IDLE; takes priority over all other transitions.
  - Next state IDLE; enter=0 and switch=0 immediately after that edge.
  - In DONE: the response is dropped, rsp_valid→0, done_cnt unchanged.
  - In IDLE: ignored.
  - abort together with rsp_ready in DONE: abort wins, no count.
- Reset mid-sequence: enter drops asynchronously. No partial response is ever presented.
- cmd_* inputs are ignored while cmd_ready=0.

Test Plan:
- Reset then command op=1, a=8'h05, b=8'h03; model ALU drives result_in=16'h0008 → enter pulses at k+3, k+6, k+9; switch=04'h1,05,03 in sequence; rsp_valid at k+20 with rsp_result=16'h0008, rsp_err=0; done_cnt=1 after rsp_ready.
- op=12 (multiply), a=8'hFF, b=8'hFF; result_in becomes 16'hFE01 9 cycles after the third enter → captured value is 16'hFE01 with WAIT_CYC=10.
- op=4'hE → full three-pulse sequence; rsp_err=1.
- Hold rsp_ready=0 for 5 cycles in DONE while toggling cmd_valid → rsp stays stable, cmd_ready=0, no new enter. Then rsp_ready=1 → IDLE and done_cnt increments.
- abort asserted during A_EN → no further enter, IDLE next cycle, no rsp_valid. Then a new command completes normally.
- rst low during B → switch=0 and enter=0 immediately. With CNT_W=8, 256 completed commands wrap done_cnt to 0.
